trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 27 ++
 rtl/trap_ctrl_if.sv | 25 ++
 rtl/trap_ctrl.sv | 147 ++++++++++++++
 tb/tb_trap_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// CSR addresses, trap cause codes and mstatus bit positions.
package trap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        W_MRET,
        JUMP
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Exception code for ECALL from M-mode and interrupt code for the
    // machine timer (the interrupt flag is the cause MSB, added by the user).
    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_M_TIMER = 7;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

endpackage

// File: rtl/trap_ctrl_if.sv
// Secondary CSR write port between the trap controller and the CSR file.
// ex_csr_we_i tells the controller the EX stage owns the CSR file this cycle.
interface trap_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
);
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              ex_csr_we_i;

    modport master (
        output csr_we_o,
        output csr_waddr_o,
        output csr_wdata_o,
        input  ex_csr_we_i
    );

    modport slave (
        input  csr_we_o,
        input  csr_waddr_o,
        input  csr_wdata_o,
        output ex_csr_we_i
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences the mepc/mcause/mstatus updates
// for ECALL and timer interrupts, the mstatus restore for MRET, and issues
// a one-cycle redirect to mtvec or mepc once the CSR writes are done.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ecall_i,
    input  logic            mret_i,
    input  logic            irq_i,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_pc_i,
    input  logic            global_int_en_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    trap_ctrl_if.master     csr,
    output logic            hold_o,
    output logic            jump_o,
    output logic [XLEN-1:0] jump_addr_o
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            hold_c;

    // Trap entry: save MIE into MPIE and disable interrupts.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r           = ms;
        r[MPIE_BIT] = ms[MIE_BIT];
        r[MIE_BIT]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r           = ms;
        r[MIE_BIT]  = ms[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

    // State and latched trap context; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    // Next-state and outputs; a write state only advances when the EX stage
    // is not using the CSR file, so a conflicting write is simply retried.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        cause_d         = cause_q;
        target_d        = target_q;
        hold_c          = 1'b0;
        jump_o          = 1'b0;
        jump_addr_o     = '0;
        csr.csr_we_o    = 1'b0;
        csr.csr_waddr_o = '0;
        csr.csr_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (ecall_i) begin
                    state_d = W_MEPC;
                    pc_d    = inst_pc_i;
                    cause_d = XLEN'(CAUSE_ECALL_M);
                    hold_c  = 1'b1;
                end else if (mret_i) begin
                    state_d = W_MRET;
                    hold_c  = 1'b1;
                end else if (irq_i && global_int_en_i && inst_valid_i) begin
                    state_d = W_MEPC;
                    pc_d    = inst_pc_i;
                    cause_d = {1'b1, (XLEN-1)'(CAUSE_M_TIMER)};
                    hold_c  = 1'b1;
                end
            end
            W_MEPC: begin
                hold_c = 1'b1;
                if (!csr.ex_csr_we_i) begin
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_AW'(CSR_MEPC);
                    csr.csr_wdata_o = pc_q;
                    state_d         = W_MCAUSE;
                end
            end
            W_MCAUSE: begin
                hold_c = 1'b1;
                if (!csr.ex_csr_we_i) begin
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                    csr.csr_wdata_o = cause_q;
                    state_d         = W_MSTATUS;
                end
            end
            W_MSTATUS: begin
                hold_c = 1'b1;
                if (!csr.ex_csr_we_i) begin
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                    csr.csr_wdata_o = trap_mstatus(csr_mstatus_i);
                    target_d        = csr_mtvec_i;
                    state_d         = JUMP;
                end
            end
            W_MRET: begin
                hold_c = 1'b1;
                if (!csr.ex_csr_we_i) begin
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                    csr.csr_wdata_o = mret_mstatus(csr_mstatus_i);
                    target_d        = csr_mepc_i;
                    state_d         = JUMP;
                end
            end
            JUMP: begin
                hold_c      = 1'b1;
                jump_o      = 1'b1;
                jump_addr_o = target_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The IDLE accept path is input-driven, so mask it while reset is held.
    assign hold_o = hold_c & rst_n;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: expected CSR writes and jumps (with
// their cycle numbers) are queued when an event is driven and compared as
// the controller produces them.
module tb_trap_ctrl;
    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    typedef struct {
        bit          is_jump;
        logic [11:0] addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ecall_i, mret_i, irq_i, inst_valid_i, global_int_en_i;
    logic [XLEN-1:0] inst_pc_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic            hold_o, jump_o;
    logic [XLEN-1:0] jump_addr_o;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    trap_ctrl_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus ();

    trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ecall_i         (ecall_i),
        .mret_i          (mret_i),
        .irq_i           (irq_i),
        .inst_valid_i    (inst_valid_i),
        .inst_pc_i       (inst_pc_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .csr             (bus.master),
        .hold_o          (hold_o),
        .jump_o          (jump_o),
        .jump_addr_o     (jump_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every write or jump must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.csr_we_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", bus.csr_waddr_o, bus.csr_wdata_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_jump || bus.csr_waddr_o !== mon_e.addr || bus.csr_wdata_o !== mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL csr_write got addr=%h data=%h cyc=%0d want jump=%0d addr=%h data=%h cyc=%0d",
                                 bus.csr_waddr_o, bus.csr_wdata_o, cyc, mon_e.is_jump, mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
            end else begin
                checks++;
                if (bus.csr_waddr_o !== '0 || bus.csr_wdata_o !== '0) begin
                    errors++;
                    $display("FAIL idle_bus addr=%h data=%h want 0/0", bus.csr_waddr_o, bus.csr_wdata_o);
                end
            end
            if (jump_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_jump addr=%h cyc=%0d", jump_addr_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (!mon_e.is_jump || jump_addr_o !== mon_e.data || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL jump got addr=%h cyc=%0d want jump=%0d addr=%h cyc=%0d",
                                 jump_addr_o, cyc, mon_e.is_jump, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [63:0] d, input int c);
        sb.push_back('{is_jump: 1'b0, addr: a, data: d, cyc: c});
    endtask

    task automatic push_jmp(input logic [63:0] d, input int c);
        sb.push_back('{is_jump: 1'b1, addr: 12'h0, data: d, cyc: c});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ecall_i = 1'b1; mret_i = 1'b0; irq_i = 1'b1;
        inst_valid_i = 1'b1; global_int_en_i = 1'b1; inst_pc_i = 64'h1234;
        csr_mtvec_i = 64'h8000_0100; csr_mepc_i = '0; csr_mstatus_i = 64'h8;
        bus.ex_csr_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hold_o !== 1'b0 || jump_o !== 1'b0 || jump_addr_o !== '0 ||
            bus.csr_we_o !== 1'b0 || bus.csr_waddr_o !== '0 || bus.csr_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs hold=%b jump=%b jaddr=%h we=%b addr=%h data=%h want all 0",
                     hold_o, jump_o, jump_addr_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        end
        ecall_i = 1'b0; irq_i = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (hold_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_hold got %b want 0", hold_o);
        end
    endtask

    task automatic test_ecall();
        int c;
        tick();
        inst_pc_i = 64'h8000_0010; csr_mtvec_i = 64'h8000_0100; csr_mstatus_i = 64'h8;
        ecall_i = 1'b1;
        c = cyc;
        push_wr(12'h341, 64'h8000_0010, c + 1);
        push_wr(12'h342, 64'd11, c + 2);
        push_wr(12'h300, 64'h80, c + 3);
        push_jmp(64'h8000_0100, c + 4);
        @(negedge clk);
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL ecall_accept_hold got %b want 1", hold_o);
        end
        tick();
        ecall_i = 1'b0;
        drain("ecall");
    endtask

    task automatic test_irq();
        int c;
        tick();
        inst_pc_i = 64'h8000_0020; csr_mtvec_i = 64'h8000_0200; csr_mstatus_i = 64'h8;
        global_int_en_i = 1'b1; inst_valid_i = 1'b1; irq_i = 1'b1;
        c = cyc;
        push_wr(12'h341, 64'h8000_0020, c + 1);
        push_wr(12'h342, 64'h8000_0000_0000_0007, c + 2);
        push_wr(12'h300, 64'h80, c + 3);
        push_jmp(64'h8000_0200, c + 4);
        tick();
        irq_i = 1'b0;
        drain("irq");
        // Interrupts disabled: a pending request must be ignored.
        global_int_en_i = 1'b0; irq_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (hold_o !== 1'b0 || bus.csr_we_o !== 1'b0) begin
                errors++;
                $display("FAIL irq_masked hold=%b we=%b want 0/0", hold_o, bus.csr_we_o);
            end
        end
        tick();
        irq_i = 1'b0;
    endtask

    task automatic test_mret();
        int c;
        tick();
        csr_mepc_i = 64'h8000_0024; csr_mstatus_i = 64'h80;
        mret_i = 1'b1;
        c = cyc;
        push_wr(12'h300, 64'h88, c + 1);
        push_jmp(64'h8000_0024, c + 2);
        @(negedge clk);
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL mret_accept_hold got %b want 1", hold_o);
        end
        tick();
        mret_i = 1'b0;
        drain("mret");
    endtask

    task automatic test_priority();
        int c;
        tick();
        inst_pc_i = 64'h8000_0030; csr_mtvec_i = 64'h8000_0100; csr_mstatus_i = 64'h8;
        csr_mepc_i = 64'h8000_0999; global_int_en_i = 1'b1; inst_valid_i = 1'b1;
        ecall_i = 1'b1; mret_i = 1'b1; irq_i = 1'b1;
        c = cyc;
        push_wr(12'h341, 64'h8000_0030, c + 1);
        push_wr(12'h342, 64'd11, c + 2);
        push_wr(12'h300, 64'h80, c + 3);
        push_jmp(64'h8000_0100, c + 4);
        tick();
        ecall_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
        drain("priority");
    endtask

    task automatic test_conflict();
        int c;
        tick();
        inst_pc_i = 64'h8000_0040; csr_mtvec_i = 64'h8000_0100; csr_mstatus_i = 64'h8;
        ecall_i = 1'b1;
        c = cyc;
        push_wr(12'h341, 64'h8000_0040, c + 1);
        push_wr(12'h342, 64'd11, c + 4);
        push_wr(12'h300, 64'h80, c + 5);
        push_jmp(64'h8000_0100, c + 6);
        tick();
        ecall_i = 1'b0;
        tick();
        bus.ex_csr_we_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.csr_we_o !== 1'b0 || hold_o !== 1'b1) begin
                errors++;
                $display("FAIL conflict_stall we=%b hold=%b want 0/1", bus.csr_we_o, hold_o);
            end
            tick();
        end
        bus.ex_csr_we_i = 1'b0;
        drain("conflict");
    endtask

    task automatic test_back_to_back();
        int c;
        tick();
        csr_mepc_i = 64'h8000_0050; csr_mstatus_i = 64'h80; csr_mtvec_i = 64'h8000_0300;
        mret_i = 1'b1;
        c = cyc;
        push_wr(12'h300, 64'h88, c + 1);
        push_jmp(64'h8000_0050, c + 2);
        push_wr(12'h341, 64'h8000_0060, c + 4);
        push_wr(12'h342, 64'd11, c + 5);
        push_wr(12'h300, 64'h80, c + 6);
        push_jmp(64'h8000_0300, c + 7);
        tick();
        mret_i = 1'b0;
        tick();
        // ECALL seen during the JUMP cycle is ignored, accepted next cycle.
        ecall_i = 1'b1; inst_pc_i = 64'h8000_0060; csr_mstatus_i = 64'h8;
        tick();
        @(negedge clk);
        checks++;
        if (hold_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_hold got %b want 1", hold_o);
        end
        tick();
        ecall_i = 1'b0;
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        int c;
        tick();
        inst_pc_i = 64'h8000_0070; csr_mtvec_i = 64'h8000_0100; csr_mstatus_i = 64'h8;
        ecall_i = 1'b1;
        c = cyc;
        push_wr(12'h341, 64'h8000_0070, c + 1);
        tick();
        ecall_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (hold_o !== 1'b0 || jump_o !== 1'b0 || jump_addr_o !== '0 ||
            bus.csr_we_o !== 1'b0 || bus.csr_waddr_o !== '0 || bus.csr_wdata_o !== '0) begin
            errors++;
            $display("FAIL midreset_outputs hold=%b jump=%b jaddr=%h we=%b addr=%h data=%h want all 0",
                     hold_o, jump_o, jump_addr_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (hold_o !== 1'b0 || jump_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after hold=%b jump=%b want 0/0", hold_o, jump_o);
            end
        end
        drain("midreset");
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq();
        test_mret();
        test_priority();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
